// File: rtl/serial_divisibility_scheduler.sv
// Round-robin front end sharing one bit-serial modulo-DIVISOR residue engine
// between N_REQ requesters; results are returned tagged with the requester index.
module serial_divisibility_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 5,
    localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int RW     = $clog2(DIVISOR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IW-1:0]          res_id,
    output logic                   res_div,
    output logic [RW-1:0]          res_rem,
    output logic                   busy
);

    localparam int            CW    = $clog2(WIDTH + 1);
    localparam logic [RW:0]   DIV_W = (RW + 1)'(DIVISOR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [IW-1:0]    ptr_r;
    logic [WIDTH-1:0] sh_r;
    logic [RW-1:0]    rem_r;
    logic [CW-1:0]    cnt_r;
    logic             res_valid_r;
    logic [IW-1:0]    res_id_r;
    logic             res_div_r;
    logic [RW-1:0]    res_rem_r;
    logic             busy_r;

    logic [IW-1:0]    grant_s;
    logic             any_s;
    logic [RW-1:0]    rem_next_s;

    // One residue step: 2*rem+bit never reaches 2*DIVISOR, so a single
    // conditional subtract replaces the modulo.
    function automatic logic [RW-1:0] mod_step(input logic [RW-1:0] rem, input logic in_bit);
        logic [RW:0] dbl;
        dbl = {rem, in_bit};
        if (dbl >= DIV_W) begin
            mod_step = RW'(dbl - DIV_W);
        end else begin
            mod_step = dbl[RW-1:0];
        end
    endfunction

    // Round-robin pick: scanning from farthest to nearest lets the index
    // closest after ptr overwrite the others.
    always_comb begin
        grant_s = '0;
        any_s   = |req_valid;
        for (int k = N_REQ; k >= 1; k--) begin
            int idx;
            idx     = (int'(ptr_r) + k) % N_REQ;
            grant_s = req_valid[idx] ? IW'(idx) : grant_s;
        end
    end

    // Grant is offered combinationally, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_r == ST_IDLE) && any_s) begin
            req_ready = N_REQ'(1) << grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next residue from the current MSB of the shift register.
    always_comb begin
        rem_next_s = mod_step(rem_r, sh_r[WIDTH-1]);
    end

    // Arbitration, serial engine and result holding FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= IW'(N_REQ - 1);
            sh_r        <= '0;
            rem_r       <= '0;
            cnt_r       <= '0;
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            res_div_r   <= 1'b0;
            res_rem_r   <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        sh_r     <= req_data[grant_s*WIDTH +: WIDTH];
                        rem_r    <= '0;
                        cnt_r    <= CW'(WIDTH);
                        res_id_r <= grant_s;
                        ptr_r    <= grant_s;
                        busy_r   <= 1'b1;
                        state_r  <= ST_SHIFT;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    rem_r <= rem_next_s;
                    sh_r  <= sh_r << 1;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        res_rem_r   <= rem_next_s;
                        res_div_r   <= (rem_next_s == '0);
                        res_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r     <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_div   = res_div_r;
    assign res_rem   = res_rem_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_serial_divisibility_scheduler.sv
// Scoreboard bench: stimulus pushes hand-computed results, monitors pop and
// compare on each result handshake; a second instance covers a 12-bit mod-3 setup.
module tb_serial_divisibility_scheduler;

    localparam int N_REQ = 4, WIDTH = 8, DIVISOR = 5;
    localparam int B_N = 2, B_W = 12, B_D = 3;

    typedef struct {
        int id;
        int rem;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   res_valid, res_ready, res_div, busy;
    logic [1:0]             res_id;
    logic [2:0]             res_rem;

    logic [B_N-1:0]         b_req_valid;
    logic [B_N*B_W-1:0]     b_req_data;
    logic [B_N-1:0]         b_req_ready;
    logic                   b_res_valid, b_res_ready, b_res_div, b_busy;
    logic [0:0]             b_res_id;
    logic [1:0]             b_res_rem;

    serial_divisibility_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_div(res_div), .res_rem(res_rem), .busy(busy)
    );

    serial_divisibility_scheduler #(.N_REQ(B_N), .WIDTH(B_W), .DIVISOR(B_D)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_ready(b_req_ready), .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_id(b_res_id), .res_div(b_res_div), .res_rem(b_res_rem), .busy(b_busy)
    );

    int checks = 0, errors = 0;
    exp_t exp_a[$], exp_b[$];
    int acc_a[$], acc_b[$], acc_log_cyc[$], acc_log_id[$];
    int hs_cyc = 0, rr0_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor for the default instance: accepts, latency, hold and scoreboard.
    initial begin
        logic rv_d, rr_d, div_d;
        int   id_d, rem_d;
        exp_t e;
        rv_d = 1'b0; rr_d = 1'b0; div_d = 1'b0; id_d = 0; rem_d = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_a.delete();
                rv_d = 1'b0;
            end else begin
                if ((req_valid & req_ready) != '0) begin
                    check("ready_onehot", $countones(req_ready), 1);
                    acc_a.push_back(cyc);
                    acc_log_cyc.push_back(cyc);
                    for (int i = 0; i < N_REQ; i++)
                        if (req_valid[i] && req_ready[i]) acc_log_id.push_back(i);
                end
                if (req_ready[0]) rr0_cnt++;
                // accept observed before edge T, result observed after edge T+WIDTH
                if (res_valid && !rv_d) begin
                    if (acc_a.size() > 0) check("latency", cyc - acc_a.pop_front(), WIDTH + 1);
                    else check("result_without_accept", 1, 0);
                end
                if (res_valid && rv_d && !rr_d) begin
                    check("hold_id", int'(res_id), id_d);
                    check("hold_rem", int'(res_rem), rem_d);
                    check("hold_div", int'(res_div), int'(div_d));
                    check("ready_in_done", int'(req_ready), 0);
                end
                if (res_valid && res_ready) begin
                    hs_cyc = cyc;
                    if (exp_a.size() > 0) begin
                        e = exp_a.pop_front();
                        check("res_id", int'(res_id), e.id);
                        check("res_rem", int'(res_rem), e.rem);
                        check("res_div", int'(res_div), (e.rem == 0) ? 1 : 0);
                    end else begin
                        check("unexpected_result", 1, 0);
                    end
                end
                rv_d = res_valid; rr_d = res_ready;
                id_d = int'(res_id); rem_d = int'(res_rem); div_d = res_div;
            end
        end
    end

    // Monitor for the 12-bit mod-3 instance.
    initial begin
        logic rv_d;
        exp_t e;
        rv_d = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_b.delete();
                rv_d = 1'b0;
            end else begin
                if ((b_req_valid & b_req_ready) != '0) acc_b.push_back(cyc);
                if (b_res_valid && !rv_d) begin
                    if (acc_b.size() > 0) check("b_latency", cyc - acc_b.pop_front(), B_W + 1);
                    else check("b_result_without_accept", 1, 0);
                end
                if (b_res_valid && b_res_ready) begin
                    if (exp_b.size() > 0) begin
                        e = exp_b.pop_front();
                        check("b_res_id", int'(b_res_id), e.id);
                        check("b_res_rem", int'(b_res_rem), e.rem);
                        check("b_res_div", int'(b_res_div), (e.rem == 0) ? 1 : 0);
                    end else begin
                        check("b_unexpected_result", 1, 0);
                    end
                end
                rv_d = b_res_valid;
            end
        end
    end

    task automatic send_a(input int idx, input int data, input int rem, input bit expect_res);
        int n;
        @(posedge clk); #2;
        req_data[idx*WIDTH +: WIDTH] = WIDTH'(data);
        req_valid[idx] = 1'b1;
        if (expect_res) exp_a.push_back('{id: idx, rem: rem});
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (req_ready[idx]) break;
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        @(posedge clk); #2;
        req_valid[idx] = 1'b0;
    endtask

    task automatic send_b(input int idx, input int data, input int rem);
        int n;
        @(posedge clk); #2;
        b_req_data[idx*B_W +: B_W] = B_W'(data);
        b_req_valid[idx] = 1'b1;
        exp_b.push_back('{id: idx, rem: rem});
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (b_req_ready[idx]) break;
            n++;
        end
        if (n >= 100) check("b_accept_timeout", 0, 1);
        @(posedge clk); #2;
        b_req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || res_valid || b_busy || b_res_valid) && n < 200);
        if (n >= 200) check("idle_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, int'(req_ready), 0);
        check({tag, "_res_valid"}, int'(res_valid), 0);
        check({tag, "_res_id"}, int'(res_id), 0);
        check({tag, "_res_div"}, int'(res_div), 0);
        check({tag, "_res_rem"}, int'(res_rem), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[5];
        int n;
        ord = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; res_ready = 1'b1;
        b_req_valid = '0; b_req_data = '0; b_res_ready = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 4'b0001;
        #1;
        check_reset_outputs("rst");
        req_valid = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // single request: 35 mod 5 = 0, ready for exactly one cycle
        rr0_cnt = 0;
        send_a(0, 35, 0, 1'b1);
        wait_idle();
        check("req0_ready_cycles", rr0_cnt, 1);

        // remainder values
        send_a(2, 37, 2, 1'b1);  wait_idle();
        send_a(1, 255, 0, 1'b1); wait_idle();
        send_a(3, 0, 0, 1'b1);   wait_idle();
        send_a(0, 1, 1, 1'b1);   wait_idle();

        // arbitration from reset with all four requesters held valid
        @(posedge clk); #2; rst_n = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
        acc_log_cyc.delete(); acc_log_id.delete();
        req_data = {8'd49, 8'd22, 8'd13, 8'd10};
        exp_a.push_back('{id: 0, rem: 0});
        exp_a.push_back('{id: 1, rem: 3});
        exp_a.push_back('{id: 2, rem: 2});
        exp_a.push_back('{id: 3, rem: 4});
        exp_a.push_back('{id: 0, rem: 0});
        req_valid = 4'hF;
        n = 0;
        while (acc_log_cyc.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #2;
        req_valid = '0;
        if (acc_log_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("grant_order", acc_log_id[i], ord[i]);
            // consecutive accept edges WIDTH+2 apart: WIDTH+1 cycles between them
            for (int i = 1; i < 5; i++)
                check("accept_spacing", acc_log_cyc[i] - acc_log_cyc[i-1], WIDTH + 2);
        end else begin
            check("arb_accept_count", acc_log_id.size(), 5);
        end
        wait_idle();

        // backpressure with requester 1 pending
        res_ready = 1'b0;
        send_a(0, 7, 2, 1'b1);
        req_data[1*WIDTH +: WIDTH] = 8'd21;
        req_valid[1] = 1'b1;
        exp_a.push_back('{id: 1, rem: 1});
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_res_valid_seen", int'(res_valid), 1);
        repeat (6) @(negedge clk);
        @(posedge clk); #2;
        res_ready = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (req_ready[1]) break;
            n++;
        end
        @(posedge clk); #1;
        check("accept_after_handshake", acc_log_cyc[$] - hs_cyc, 1);
        #1;
        req_valid[1] = 1'b0;
        wait_idle();

        // reset mid-SHIFT discards the in-flight result
        send_a(3, 40, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_result_after_reset", int'(res_valid), 0);
        send_a(1, 44, 4, 1'b1);
        wait_idle();

        // 12-bit, mod-3, two requesters
        send_b(0, 2049, 0); wait_idle();
        send_b(1, 2050, 1); wait_idle();

        check("scoreboard_a_empty", exp_a.size(), 0);
        check("scoreboard_b_empty", exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
